// File: rtl/core_run_controller_if.sv
// ---------------------------------------------------------------------------
// core_run_controller_if
//   Control/status bundle between a run requester and core_run_controller.
//
//   start        requester -> controller  one-cycle run launch request
//   core_mask    requester -> controller  cores to run, latched on launch
//   abort        requester -> controller  cancel the active run
//   end_process  requester -> controller  per-core completion level flags
//   status0..3   controller -> requester  per-core run command (01 on, 00 off)
//   busy         controller -> requester  run in LAUNCH or RUN
//   done         controller -> requester  one-cycle pulse on completion
//   timeout      controller -> requester  one-cycle pulse on timeout/abort
//   cycle_count  controller -> requester  RUN cycles of last/current run
// ---------------------------------------------------------------------------
interface core_run_controller_if #(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 16
);
  logic                 start;
  logic [NUM_CORES-1:0] core_mask;
  logic                 abort;
  logic [NUM_CORES-1:0] end_process;
  logic [1:0]           status0;
  logic [1:0]           status1;
  logic [1:0]           status2;
  logic [1:0]           status3;
  logic                 busy;
  logic                 done;
  logic                 timeout;
  logic [CNT_W-1:0]     cycle_count;

  modport master (
    output start, core_mask, abort, end_process,
    input  status0, status1, status2, status3, busy, done, timeout, cycle_count
  );

  modport slave (
    input  start, core_mask, abort, end_process,
    output status0, status1, status2, status3, busy, done, timeout, cycle_count
  );
endinterface

// File: rtl/core_run_controller.sv
// ---------------------------------------------------------------------------
// core_run_controller
//   Launches a run on a masked set of processor cores, tracks per-core
//   completion, counts RUN cycles and ends the run by completion, timeout
//   or abort. All outputs come straight from flops.
//
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      core_run_controller_if.slave (see interface header)
// ---------------------------------------------------------------------------
module core_run_controller #(
  parameter int NUM_CORES      = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 16'hFFF0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  core_run_controller_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_FINISH,
    S_ABORT
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_t               state_q, state_n;
  logic [NUM_CORES-1:0] mask_q, mask_n;
  logic [NUM_CORES-1:0] fin_q, fin_n;
  logic [NUM_CORES-1:0] on_q, on_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic                 busy_q, busy_n;
  logic                 done_q, done_n;
  logic                 timeout_q, timeout_n;
  logic [3:0]           status_on;

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state_q;
    mask_n  = mask_q;
    fin_n   = fin_q;
    cnt_n   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && (|bus.core_mask)) begin
          mask_n  = bus.core_mask;
          state_n = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_n   = '0;
        fin_n   = '0;
        state_n = bus.abort ? S_ABORT : S_RUN;
      end
      S_RUN: begin
        fin_n = fin_q | (bus.end_process & mask_q);
        cnt_n = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        // Completion wins over abort and timeout in the same cycle.
        if ((fin_n & mask_q) == mask_q)
          state_n = S_FINISH;
        else if (bus.abort || (cnt_n >= TIMEOUT_LIM))
          state_n = S_ABORT;
      end
      S_FINISH,
      S_ABORT: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they land in flops and
    // line up with the state they describe.
    busy_n    = (state_n == S_LAUNCH) || (state_n == S_RUN);
    done_n    = (state_n == S_FINISH);
    timeout_n = (state_n == S_ABORT);
    on_n      = (state_n == S_RUN) ? (mask_n & ~fin_n) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: all flops, including the mask and finished vectors, are reset so a
  // mid-run reset leaves no stale run context behind.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      fin_q     <= '0;
      on_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      mask_q    <= mask_n;
      fin_q     <= fin_n;
      on_q      <= on_n;
      cnt_q     <= cnt_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      timeout_q <= timeout_n;
    end
  end

  // Only four status ports exist; extra cores have no status output and
  // missing cores read as off.
  assign status_on = 4'(on_q);

  assign bus.status0     = {1'b0, status_on[0]};
  assign bus.status1     = {1'b0, status_on[1]};
  assign bus.status2     = {1'b0, status_on[2]};
  assign bus.status3     = {1'b0, status_on[3]};
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_core_run_controller.sv
// ---------------------------------------------------------------------------
// tb_core_run_controller
//   Directed bench for core_run_controller (TIMEOUT_CYCLES = 20). Inputs are
//   driven 1 time unit after each rising edge; outputs are observed at the
//   same point, i.e. they show the state entered on that edge.
// ---------------------------------------------------------------------------
module tb_core_run_controller;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  core_run_controller_if #(.NUM_CORES(4), .CNT_W(16)) bus ();

  core_run_controller #(
    .NUM_CORES      (4),
    .CNT_W          (16),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] status_vec();
    return {bus.status3, bus.status2, bus.status1, bus.status0};
  endfunction

  // {timeout, done, busy}
  function automatic logic [2:0] flags();
    return {bus.timeout, bus.done, bus.busy};
  endfunction

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    reset_n         = 1'b0;
    bus.start       = 1'b0;
    bus.core_mask   = 4'b0000;
    bus.abort       = 1'b0;
    bus.end_process = 4'b0000;

    // Reset state
    #2;
    check("reset_status", 32'(status_vec()), 32'h00);
    check("reset_flags", 32'(flags()), 32'h0);
    check("reset_count", 32'(bus.cycle_count), 32'h0);
    step();
    step();
    reset_n = 1'b1;

    // Start with empty mask is ignored
    bus.start = 1'b1;
    bus.core_mask = 4'b0000;
    step();
    bus.start = 1'b0;
    check("empty_mask_busy", 32'(flags()), 32'h0);
    step();
    check("empty_mask_idle", 32'(flags()), 32'h0);
    check("empty_mask_status", 32'(status_vec()), 32'h00);

    // Two-core run, with a start during RUN that must be ignored
    bus.start = 1'b1;
    bus.core_mask = 4'b0011;
    step();
    bus.start = 1'b0;
    check("t1_launch_flags", 32'(flags()), 32'h1);
    check("t1_launch_status", 32'(status_vec()), 32'h00);
    step();
    for (int r = 1; r <= 9; r++) begin
      check($sformatf("t1_status_r%0d", r), 32'(status_vec()), (r <= 5) ? 32'h05 : 32'h04);
      check($sformatf("t1_count_r%0d", r), 32'(bus.cycle_count), 32'(r - 1));
      check($sformatf("t1_flags_r%0d", r), 32'(flags()), 32'h1);
      bus.start       = (r == 3);
      bus.core_mask   = (r == 3) ? 4'b1111 : 4'b0011;
      bus.end_process = {2'b00, (r == 9), (r >= 5)};
      step();
    end
    bus.end_process = 4'b0000;
    check("t1_finish_flags", 32'(flags()), 32'h2);
    check("t1_finish_status", 32'(status_vec()), 32'h00);
    check("t1_finish_count", 32'(bus.cycle_count), 32'd9);
    step();
    check("t1_idle_flags", 32'(flags()), 32'h0);
    check("t1_idle_count_hold", 32'(bus.cycle_count), 32'd9);

    // Unmasked end_process noise
    bus.start = 1'b1;
    bus.core_mask = 4'b0001;
    step();
    bus.start = 1'b0;
    bus.end_process = 4'b1110;
    step();
    check("t2_r1_status", 32'(status_vec()), 32'h01);
    step();
    check("t2_r2_flags", 32'(flags()), 32'h1);
    step();
    check("t2_r3_flags", 32'(flags()), 32'h1);
    bus.end_process = 4'b1111;
    step();
    bus.end_process = 4'b0000;
    check("t2_finish_flags", 32'(flags()), 32'h2);
    check("t2_finish_count", 32'(bus.cycle_count), 32'd3);
    step();

    // Timeout after 20 RUN cycles
    bus.start = 1'b1;
    bus.core_mask = 4'b1111;
    step();
    bus.start = 1'b0;
    for (int r = 1; r <= 20; r++) step();
    check("t3_r20_count", 32'(bus.cycle_count), 32'd19);
    check("t3_r20_status", 32'(status_vec()), 32'h55);
    check("t3_r20_flags", 32'(flags()), 32'h1);
    step();
    check("t3_abort_flags", 32'(flags()), 32'h4);
    check("t3_abort_status", 32'(status_vec()), 32'h00);
    check("t3_abort_count", 32'(bus.cycle_count), 32'd20);
    step();
    check("t3_idle_flags", 32'(flags()), 32'h0);

    // Abort coincident with completion: completion wins
    bus.start = 1'b1;
    bus.core_mask = 4'b0010;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.end_process = 4'b0010;
    bus.abort = 1'b1;
    step();
    bus.end_process = 4'b0000;
    bus.abort = 1'b0;
    check("t4_finish_flags", 32'(flags()), 32'h2);
    check("t4_finish_count", 32'(bus.cycle_count), 32'd2);
    step();

    // Plain abort in RUN
    bus.start = 1'b1;
    bus.core_mask = 4'b0001;
    step();
    bus.start = 1'b0;
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("t5_abort_flags", 32'(flags()), 32'h4);
    check("t5_abort_count", 32'(bus.cycle_count), 32'd1);
    step();
    check("t5_idle_flags", 32'(flags()), 32'h0);

    // Reset mid-run, then a fresh single-core run
    bus.start = 1'b1;
    bus.core_mask = 4'b1111;
    step();
    bus.start = 1'b0;
    for (int r = 1; r <= 4; r++) step();
    check("t6_r4_count", 32'(bus.cycle_count), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_status", 32'(status_vec()), 32'h00);
    check("t6_rst_flags", 32'(flags()), 32'h0);
    check("t6_rst_count", 32'(bus.cycle_count), 32'h0);
    #1;
    reset_n = 1'b1;
    bus.start = 1'b1;
    bus.core_mask = 4'b0100;
    step();
    bus.start = 1'b0;
    check("t6_launch_flags", 32'(flags()), 32'h1);
    step();
    check("t6_run_status", 32'(status_vec()), 32'h10);
    bus.end_process = 4'b0100;
    step();
    bus.end_process = 4'b0000;
    check("t6_finish_flags", 32'(flags()), 32'h2);
    check("t6_finish_count", 32'(bus.cycle_count), 32'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_run_controller.md
CORE_RUN_CONTROLLER -- requirements
Module: core_run_controller

Interface
REQ-001 Parameter NUM_CORES, default 4, number of processor cores controlled.
REQ-002 Parameter CNT_W, default 16, width of the run-cycle counter.
REQ-003 Parameter TIMEOUT_CYCLES, default 16'hFFF0, number of RUN cycles after which a run is aborted.
REQ-004 clock  input  1  the single system clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset; one clock; polarity and synchronicity fixed.
REQ-006 start  input  1  single-cycle request to launch a run; sampled only in IDLE.
REQ-007 core_mask  input  NUM_CORES  cores to run; latched when start is accepted.
REQ-008 abort  input  1  synchronous request to cancel the active run.
REQ-009 end_process  input  NUM_CORES  per-core level completion flags from the processor.
REQ-010 status0..status3  output  2 each  per-core run command: 2'b01 on, 2'b00 off; 2'b10 and 2'b11 never driven.
REQ-011 busy  output  1  high in LAUNCH and RUN.
REQ-012 done  output  1  one-cycle pulse when every masked core has finished.
REQ-013 timeout  output  1  one-cycle pulse when a run ends by timeout or abort.
REQ-014 cycle_count  output  CNT_W  RUN cycles of the last or current run.

Function
REQ-015 The FSM SHALL have states IDLE, LAUNCH, RUN, FINISH and ABORT.
REQ-016 IDLE: start=1 with core_mask!=0 -> latch mask, go to LAUNCH next cycle; start with core_mask==0 -> ignored, stay IDLE.
REQ-017 LAUNCH lasts exactly one cycle: it clears cycle_count and the sticky finished vector, then enters RUN.
REQ-018 Entering RUN, statusN is 2'b01 for each latched-mask core and 2'b00 otherwise; the first 2'b01 appears the cycle after LAUNCH.
REQ-019 In RUN, cycle_count increments by 1 every cycle and saturates at all-ones.
REQ-020 In RUN, end_process[i]=1 for a masked core sets sticky finished[i]; statusI returns to 2'b00 the following cycle and stays off until the next LAUNCH.
REQ-021 end_process bits of unmasked cores and end_process in any state other than RUN are ignored.
REQ-022 When (finished | this-cycle end_process) & mask == mask, the FSM enters FINISH next cycle; cycle_count then equals the number of RUN cycles, including the completing cycle.
REQ-023 FINISH lasts one cycle: done=1, all status 2'b00, then IDLE; cycle_count holds until the next LAUNCH.
REQ-024 In RUN, if cycle_count reaches TIMEOUT_CYCLES and completion (REQ-022) is not met in the same cycle, the FSM enters ABORT.
REQ-025 abort=1 in LAUNCH or RUN enters ABORT next cycle. Completion in the same cycle takes priority over abort and timeout, and the FSM enters FINISH.
REQ-026 ABORT lasts one cycle: timeout=1, all status 2'b00, then IDLE; cycle_count holds.
REQ-027 start in any state other than IDLE is ignored and not queued; abort in IDLE, FINISH or ABORT is ignored.
REQ-028 done and timeout SHALL never be high together; busy is low in IDLE, FINISH and ABORT.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 reset_n=0 SHALL immediately force IDLE, all status 2'b00, busy=0, done=0, timeout=0, cycle_count=0, and clear the mask and finished vectors, including mid-run.
REQ-031 After reset_n deasserts, the first start is accepted on the first rising clock edge.

Verification
REQ-032 Two-core run: mask 4'b0011, start; end_process[0] after 5 RUN cycles, end_process[1] after 9 -> status0 off after 6 cycles, done pulse, cycle_count=9, status2/3 stay 2'b00 throughout.
REQ-033 Unmasked noise: mask 4'b0001, end_process=4'b1110 held throughout RUN -> no done; end_process[0]=1 at RUN cycle 3 -> done, cycle_count=3.
REQ-034 Timeout: TIMEOUT_CYCLES=20, mask 4'b1111, no end_process -> timeout pulse after RUN cycle 20, no done, all status 2'b00, return to IDLE.
REQ-035 Abort vs completion: abort asserted in the same RUN cycle as the final end_process -> done=1, timeout=0.
REQ-036 Reset mid-run: reset_n low at RUN cycle 4 -> outputs zero asynchronously before the next edge; new start with mask 4'b0100 -> only status2=2'b01.
REQ-037 Ignored inputs: start during RUN and start with mask 4'b0000 in IDLE -> no state change, no extra LAUNCH.
